// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Purpose  : RISC-V I/S/B/U/J immediate generator behind a valid/ready
//            handshake, with a 2-entry skid buffer (OREG + SREG).
// Options  : IMMGEN_ILLEGAL_EN adds the Illegal_o output and funct3 checks.
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             In_valid_i,
  output logic             In_ready_o,
  input  logic [31:0]      Inst_i,
  input  logic [TAG_W-1:0] Tag_i,
  output logic             Out_valid_o,
  input  logic             Out_ready_i,
  output logic [XLEN-1:0]  Imm_o,
  output logic [2:0]       ImmType_o,
  output logic [TAG_W-1:0] Tag_o
`ifdef IMMGEN_ILLEGAL_EN
  ,
  output logic             Illegal_o
`endif
);

  localparam logic [2:0] c_TYPE_NONE = 3'd0;
  localparam logic [2:0] c_TYPE_I    = 3'd1;
  localparam logic [2:0] c_TYPE_S    = 3'd2;
  localparam logic [2:0] c_TYPE_B    = 3'd3;
  localparam logic [2:0] c_TYPE_U    = 3'd4;
  localparam logic [2:0] c_TYPE_J    = 3'd5;

  localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;

  localparam int c_PW = XLEN + 3 + TAG_W;

  logic [31:0]     w_imm32;
  logic [2:0]      w_type;
  logic [c_PW-1:0] w_new;
  logic            w_accept;
  logic            w_out_xfer;
  logic            w_o_load_new;
  logic            w_o_load_skid;
  logic            w_s_load;

  logic            r_o_valid;
  logic            r_s_valid;
  logic [c_PW-1:0] r_o_data;
  logic [c_PW-1:0] r_s_data;

`ifdef IMMGEN_ILLEGAL_EN
  logic            w_ill;
  logic            r_o_ill;
  logic            r_s_ill;
`endif

  // All formats place Inst_i[31] at bit 31 of the 32-bit value, so a single
  // signed widening yields the XLEN sign extension.
  always_comb begin
    w_type  = c_TYPE_NONE;
    w_imm32 = 32'd0;
`ifdef IMMGEN_ILLEGAL_EN
    w_ill   = 1'b0;
`endif
    case (Inst_i[6:0])
      c_OPC_OP_IMM, c_OPC_LOAD: begin
        w_type  = c_TYPE_I;
        w_imm32 = {{20{Inst_i[31]}}, Inst_i[31:20]};
      end
      c_OPC_JALR: begin
        w_type  = c_TYPE_I;
        w_imm32 = {{20{Inst_i[31]}}, Inst_i[31:20]};
`ifdef IMMGEN_ILLEGAL_EN
        w_ill   = (Inst_i[14:12] != 3'b000);
`endif
      end
      c_OPC_STORE: begin
        w_type  = c_TYPE_S;
        w_imm32 = {{20{Inst_i[31]}}, Inst_i[31:25], Inst_i[11:7]};
      end
      c_OPC_BRANCH: begin
        w_type  = c_TYPE_B;
        w_imm32 = {{19{Inst_i[31]}}, Inst_i[31], Inst_i[7], Inst_i[30:25],
                   Inst_i[11:8], 1'b0};
`ifdef IMMGEN_ILLEGAL_EN
        w_ill   = (Inst_i[14:13] == 2'b01);
`endif
      end
      c_OPC_LUI, c_OPC_AUIPC: begin
        w_type  = c_TYPE_U;
        w_imm32 = {Inst_i[31:12], 12'd0};
      end
      c_OPC_JAL: begin
        w_type  = c_TYPE_J;
        w_imm32 = {{11{Inst_i[31]}}, Inst_i[31], Inst_i[19:12], Inst_i[20],
                   Inst_i[30:21], 1'b0};
      end
      default: begin
`ifdef IMMGEN_ILLEGAL_EN
        w_ill   = 1'b1;
`endif
      end
    endcase
`ifdef IMMGEN_ILLEGAL_EN
    // Every listed opcode ends in 2'b11, so the default arm already covers
    // compressed/reserved encodings in Inst_i[1:0].
    if (w_ill) begin
      w_type  = c_TYPE_NONE;
      w_imm32 = 32'd0;
    end
`endif
  end

  assign w_new = {XLEN'($signed(w_imm32)), w_type, Tag_i};

  assign w_accept      = In_valid_i && In_ready_o;
  assign w_out_xfer    = r_o_valid && Out_ready_i;
  assign w_o_load_new  = w_accept && (!r_o_valid || (w_out_xfer && !r_s_valid));
  assign w_o_load_skid = w_out_xfer && r_s_valid;
  assign w_s_load      = w_accept && r_o_valid && !w_out_xfer;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_o_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_o_data  <= '0;
      r_s_data  <= '0;
    end else begin
      if (w_o_load_new) begin
        r_o_valid <= 1'b1;
        r_o_data  <= w_new;
      end else if (w_o_load_skid) begin
        r_o_valid <= 1'b1;
        r_o_data  <= r_s_data;
      end else if (w_out_xfer) begin
        r_o_valid <= 1'b0;
      end

      if (w_s_load) begin
        r_s_valid <= 1'b1;
        r_s_data  <= w_new;
      end else if (w_o_load_skid) begin
        r_s_valid <= 1'b0;
      end
    end
  end

`ifdef IMMGEN_ILLEGAL_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_o_ill <= 1'b0;
      r_s_ill <= 1'b0;
    end else begin
      if (w_o_load_new) begin
        r_o_ill <= w_ill;
      end else if (w_o_load_skid) begin
        r_o_ill <= r_s_ill;
      end
      if (w_s_load) begin
        r_s_ill <= w_ill;
      end
    end
  end

  assign Illegal_o = r_o_ill;
`endif

  // Ready is a pure register output: it only depends on the skid valid bit.
  assign In_ready_o  = !r_s_valid;
  assign Out_valid_o = r_o_valid;
  assign Imm_o       = r_o_data[c_PW-1 -: XLEN];
  assign ImmType_o   = r_o_data[TAG_W +: 3];
  assign Tag_o       = r_o_data[TAG_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// Testbench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus;
// a scoreboard compares both against a field-arithmetic reference model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] inst = 32'd0;
  logic [4:0]  tag = 5'd0;

  logic        rdy, ov, rdy64, ov64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  ty, ty64;
  logic [4:0]  tg, tg64;
`ifdef IMMGEN_ILLEGAL_EN
  logic        ill, ill64;
`endif

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) u32 (
    .clk(clk), .rst_n(rst_n),
    .In_valid_i(in_valid), .In_ready_o(rdy),
    .Inst_i(inst), .Tag_i(tag),
    .Out_valid_o(ov), .Out_ready_i(out_ready),
    .Imm_o(imm32), .ImmType_o(ty), .Tag_o(tg)
`ifdef IMMGEN_ILLEGAL_EN
    , .Illegal_o(ill)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) u64 (
    .clk(clk), .rst_n(rst_n),
    .In_valid_i(in_valid), .In_ready_o(rdy64),
    .Inst_i(inst), .Tag_i(tag),
    .Out_valid_o(ov64), .Out_ready_i(out_ready),
    .Imm_o(imm64), .ImmType_o(ty64), .Tag_o(tg64)
`ifdef IMMGEN_ILLEGAL_EN
    , .Illegal_o(ill64)
`endif
  );

  typedef struct packed {
    logic [2:0]  ty;
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Immediate value computed arithmetically from the field layout.
  function automatic exp_t model(input logic [31:0] in, input logic [4:0] t);
    exp_t   e;
    longint v;
    logic   bad;
    v   = 0;
    bad = 1'b0;
    e.ty = 3'd0;
    case (in[6:0])
      7'h13, 7'h03, 7'h67: begin
        e.ty = 3'd1;
        v = longint'(in[31:20]);
        if (in[31]) v -= 4096;
        if (in[6:0] == 7'h67 && in[14:12] != 3'd0) bad = 1'b1;
      end
      7'h23: begin
        e.ty = 3'd2;
        v = longint'({in[31:25], in[11:7]});
        if (in[31]) v -= 4096;
      end
      7'h63: begin
        e.ty = 3'd3;
        v = longint'({in[31], in[7], in[30:25], in[11:8]}) * 2;
        if (in[31]) v -= 8192;
        if (in[14:12] == 3'd2 || in[14:12] == 3'd3) bad = 1'b1;
      end
      7'h37, 7'h17: begin
        e.ty = 3'd4;
        v = longint'(in[31:12]) * 4096;
        if (in[31]) v -= 64'h1_0000_0000;
      end
      7'h6F: begin
        e.ty = 3'd5;
        v = longint'({in[31], in[19:12], in[20], in[30:21]}) * 2;
        if (in[31]) v -= 64'h20_0000;
      end
      default: bad = 1'b1;
    endcase
`ifdef IMMGEN_ILLEGAL_EN
    if (bad) begin
      e.ty = 3'd0;
      v = 0;
    end
    e.ill = bad;
`else
    e.ill = 1'b0;
`endif
    e.imm = v;
    e.tag = t;
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom();
    case ($urandom_range(0, 10))
      0: op = 7'h13;  1: op = 7'h03;  2: op = 7'h67;  3: op = 7'h23;
      4: op = 7'h63;  5: op = 7'h37;  6: op = 7'h17;  7: op = 7'h6F;
      8: op = 7'h0B;  9: op = 7'h33;
      default: op = r[6:0];
    endcase
    return {r[31:7], op};
  endfunction

  // Input side: record expected results at acceptance.
  always @(negedge clk) begin
    if (rst_n && in_valid && rdy) q.push_back(model(inst, tag));
  end

  // Output side: pop and compare on each output transfer; check holds.
  exp_t        e;
  logic        stalled = 1'b0;
  logic [39:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (ov && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got tag %h expected no output", tg);
        end else begin
          e = q.pop_front();
          chk("imm32", imm32, e.imm[31:0]);
          chk("imm64", imm64, e.imm);
          chk("type", ty, e.ty);
          chk("type64", ty64, e.ty);
          chk("tag", tg, e.tag);
          chk("tag64", tg64, e.tag);
          chk("valid64", ov64, 1);
`ifdef IMMGEN_ILLEGAL_EN
          chk("illegal", ill, e.ill);
          chk("illegal64", ill64, e.ill);
`endif
        end
      end
      if (ov && !out_ready) begin
        if (stalled) chk("hold_stable", {imm32, ty, tg}, held);
        stalled = 1'b1;
        held = {imm32, ty, tg};
      end else begin
        stalled = 1'b0;
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input logic [31:0] i, input logic [4:0] t);
    int n;
    n = 0;
    in_valid = 1'b1;
    inst = i;
    tag = t;
    @(negedge clk);
    while (!rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got ready 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((q.size() != 0 || ov) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tagname);
    chk({tagname, "_valid"}, ov, 0);
    chk({tagname, "_ready"}, rdy, 1);
    chk({tagname, "_imm"}, imm32, 0);
    chk({tagname, "_type"}, ty, 0);
    chk({tagname, "_tag"}, tg, 0);
    chk({tagname, "_imm64"}, imm64, 0);
    chk({tagname, "_valid64"}, ov64, 0);
    chk({tagname, "_ready64"}, rdy64, 1);
`ifdef IMMGEN_ILLEGAL_EN
    chk({tagname, "_illegal"}, ill, 0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed formats with latency check.
    out_ready = 1'b1;
    send(32'hFFF00093, 5'd1);
    chk("lat_addi", ov, 1);
    chk("addi_imm", imm32, 32'hFFFF_FFFF);
    chk("addi_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    send(32'hFE112E23, 5'd2);
    chk("sw_imm", imm32, 32'hFFFF_FFFC);
    send(32'h001000EF, 5'd3);
    chk("jal_imm", imm32, 32'h0000_0800);
    chk("jal_type", ty, 5);
    send(32'h800002B7, 5'd4);
    chk("lui_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    chk("lui_type", ty64, 4);
    send(32'h0000000B, 5'd5);
    chk("custom_type", ty, 0);
    chk("custom_imm", imm32, 0);
`ifdef IMMGEN_ILLEGAL_EN
    chk("custom_illegal", ill, 1);
    send(32'h00001067, 5'd6);
    chk("jalr_f3_illegal", ill, 1);
`endif
    drain();

    // Backpressure: tags 1,2,3 back-to-back while the consumer stalls.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    inst = 32'hFFF00093;
    tag = 5'd1;
    @(posedge clk);
    #1;
    inst = 32'hFE112E23;
    tag = 5'd2;
    @(posedge clk);
    #1;
    chk("bp_ready_low", rdy, 0);
    chk("bp_ready_low64", rdy64, 0);
    chk("bp_valid", ov, 1);
    chk("bp_tag1", tg, 1);
    inst = 32'h001000EF;
    tag = 5'd3;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_held_ready", rdy, 0);
      chk("bp_held_tag", tg, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_ready_back", rdy, 1);
    chk("bp_tag2", tg, 2);
    chk("bp_valid2", ov, 1);
    @(posedge clk);
    #1;
    chk("bp_tag3", tg, 3);
    chk("bp_valid3", ov, 1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_empty", ov, 0);
    drain();

    // Randomised traffic with random backpressure.
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 99) < 70);
      inst = rand_inst();
      tag = 5'($urandom());
      out_ready = ($urandom_range(0, 99) < 60);
      @(posedge clk);
      #1;
    end
    drain();

    // Reset while FULL, then first instruction after reset.
    out_ready = 1'b0;
    send(32'hFFF00093, 5'd7);
    send(32'hFE112E23, 5'd8);
    chk("full_ready_low", rdy, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outputs("midreset");
    rst_n = 1'b1;
    q.delete();
    out_ready = 1'b1;
    send(32'h800002B7, 5'd9);
    chk("post_reset_lat", ov, 1);
    chk("post_reset_tag", tg, 9);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the RISC-V decode stage.
- Extracts and sign-extends the immediate for I/S/B/U/J formats to XLEN bits.
- Tags each result with its format code and carries a sideband tag.
- Sits between fetch/decode and the execute operand mux, behind a valid/ready handshake.
- A 2-entry skid buffer gives full throughput under backpressure with a fully registered In_ready_o.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 5, width of the sideband tag passed through unchanged (e.g. rd index or ROB id).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- In_valid_i  input  1  instruction word valid.
- In_ready_o  output  1  block can accept an instruction this cycle.
- Inst_i  input  32  instruction word.
- Tag_i  input  TAG_W  sideband tag.
- Out_valid_o  output  1  result valid.
- Out_ready_i  input  1  consumer accepts the result.
- Imm_o  output  XLEN  sign-extended immediate.
- ImmType_o  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J; 6 and 7 are never driven.
- Tag_o  output  TAG_W  tag aligned with Imm_o.
- Illegal_o  output  1  present only with IMMGEN_ILLEGAL_EN.

Behaviour:
Opcode decode (Inst_i[6:0]):
- 0010011 OP_IMM, 0000011 LOAD, 1100111 JALR -> I: sext(Inst[31:20]).
- 0100011 STORE -> S: sext({Inst[31:25], Inst[11:7]}).
- 1100011 BRANCH -> B: sext({Inst[31], Inst[7], Inst[30:25], Inst[11:8], 0}).
- 0110111 LUI, 0010111 AUIPC -> U: sext({Inst[31:12], 12'b0}). Bit 31 is replicated when XLEN=64.
- 1101111 JAL -> J: sext({Inst[31], Inst[19:12], Inst[20], Inst[30:21], 0}).
- Any other opcode -> type NONE, Imm 0. Never X.
- Sign extension always uses Inst[31].

Handshake:
- Input transfer occurs when In_valid_i && In_ready_o.
- Output transfer occurs when Out_valid_o && Out_ready_i.
- Inputs may change freely while In_ready_o=0; they are ignored.
- Out_valid_o, Imm_o, ImmType_o and Tag_o hold stable while Out_valid_o && !Out_ready_i.

Storage and state:
- Storage: output register OREG plus skid register SREG, each holding {imm, type, tag, valid}.
- State is implied by the valid bits: EMPTY (none), ONE (OREG), FULL (OREG+SREG).
- In_ready_o = !SREG.valid, registered.

Transitions:
- EMPTY + accept -> ONE; result appears on Out_* the cycle after acceptance (latency 1).
- ONE + accept + output transfer -> ONE; OREG is overwritten with the new result (full throughput).
- ONE + accept + no output transfer -> FULL; result goes to SREG and In_ready_o drops next cycle.
- ONE + output transfer only -> EMPTY.
- FULL + output transfer -> ONE; SREG moves to OREG and In_ready_o rises next cycle. No accept is possible in FULL.
- Ordering is strictly FIFO; no result is dropped or duplicated.

Reset:
- Reset has priority over all other events, including mid-transfer; in-flight entries are discarded.
- rst_n=0 at an edge clears both valid bits.
- Output values after reset: Out_valid_o=0, In_ready_o=1, Imm_o=0, ImmType_o=0, Tag_o=0, Illegal_o=0.
- Data registers are also cleared, so no X appears on outputs.

Optional Feature:
IMMGEN_ILLEGAL_EN
- Defined:
  - Adds output port Illegal_o, registered alongside Imm_o.
  - Illegal_o=1 when the opcode is outside the table above, or Inst[1:0]!=2'b11.
  - Illegal_o=1 when JALR funct3!=000, or BRANCH funct3 is 010 or 011.
  - For an illegal instruction, ImmType_o=NONE and Imm_o=0.
- Undefined:
  - The port is absent.
  - Decode ignores funct3 and Inst[1:0]; only Inst[6:0] selects the format.

Test Plan:
1. XLEN=32, Out_ready_i=1, send 0xFFF00093 (addi x1,x0,-1) -> next cycle Out_valid_o=1, Imm_o=0xFFFFFFFF, ImmType_o=1.
2. Send 0xFE112E23 (sw x1,-4(x2)) -> Imm_o=0xFFFFFFFC, ImmType_o=2. Send 0x001000EF (jal x1,+2048) -> Imm_o=0x00000800, ImmType_o=5.
3. XLEN=64: 0x800002B7 (lui x5,0x80000) -> Imm_o=0xFFFFFFFF80000000, ImmType_o=4. 0xFFF00093 -> Imm_o=0xFFFF_FFFF_FFFF_FFFF.
4. Backpressure:
   - Stream tags 1,2,3 back-to-back with Out_ready_i=0.
   - Required: tag 1 in OREG, tag 2 in SREG, In_ready_o=0 from the cycle after tag 2 is accepted; tag 3 is held off.
   - Raise Out_ready_i -> Tag_o sequence 1,2,3 with no gaps or loss; In_ready_o=1 one cycle after tag 1 leaves.
5. Opcode 0x0000000B (custom-0) -> ImmType_o=0, Imm_o=0. With IMMGEN_ILLEGAL_EN: Illegal_o=1; 0x00001067 (jalr, funct3=001) -> Illegal_o=1.
6. Reach FULL, then drive rst_n=0 for one edge -> Out_valid_o=0, In_ready_o=1, all data outputs 0. The first instruction after reset emerges one cycle after acceptance.
